// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   CON_*     : ALU control codes that target the HI/LO resource.
//   state_e   : sequencer FSM states.
//   is_muldiv : true for any of the four HI/LO-writing control codes.
package muldiv_pkg;

    localparam logic [3:0] CON_MULTU = 4'b1100;
    localparam logic [3:0] CON_DIVU  = 4'b1101;
    localparam logic [3:0] CON_MULT  = 4'b1110;
    localparam logic [3:0] CON_DIV   = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPrep = 2'b01,
        StRun  = 2'b10,
        StFix  = 2'b11
    } state_e;

    function automatic logic is_muldiv(input logic [3:0] con);
        return (con == CON_MULTU) || (con == CON_DIVU) ||
               (con == CON_MULT)  || (con == CON_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply / restoring divide.
//   acc_i      : 2*WIDTH accumulator. Multiply: {partial product, multiplier}.
//                Divide: {remainder, dividend/quotient}.
//   operand_i  : multiplicand (multiply) or divisor (divide), as a magnitude.
//   mode_div_i : 0 multiply, 1 divide.
//   acc_o      : accumulator after this iteration; for divide, bit 0 is left
//                clear and the new quotient bit is returned on q_bit_o.
//   q_bit_o    : quotient bit produced by this iteration (0 in multiply mode).
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               mode_div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_bit_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_hi;
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;

    // Multiply: the carry out of the add becomes the top bit after the shift.
    assign mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i};
    assign mul_hi  = acc_i[0] ? mul_sum : {1'b0, acc_i[2*WIDTH-1:WIDTH]};

    // Divide: remainder after the left shift needs one extra bit before the
    // trial subtraction; the difference always fits back into WIDTH bits.
    assign rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
    assign fits    = rem_sh >= {1'b0, operand_i};
    assign rem_sub = rem_sh[WIDTH-1:0] - operand_i;

    always_comb begin
        q_bit_o = mode_div_i & fits;
        if (mode_div_i) begin
            acc_o = {(fits ? rem_sub : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o = {mul_hi, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
//   clk, rst_n        : clock, synchronous active-low reset.
//   start, con, a, b  : HI/LO-writing instruction from EX (con 11xx).
//   kill              : squash the in-flight operation.
//   hilo_rd, hilo_sel : mfhi/mflo request; sel 0 = HI, 1 = LO.
//   hilo_out          : selected HI/LO register value.
//   busy, stall       : operation in flight; pipeline freeze.
//   done, div0        : one-cycle pulses after HI/LO commit (div0 on b==0).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       con,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    input  logic             hilo_rd,
    input  logic             hilo_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div0
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         con_q, con_d;     // con[1] signed, con[0] divide
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div0_q, div0_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q_bit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               is_div, is_signed;

    assign is_div    = con_q[0];
    assign is_signed = con_q[1];

    // Magnitudes; the most negative value wraps to itself, which still reads
    // correctly as an unsigned magnitude.
    assign mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    assign prod_fix = neg_quo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i      (acc_q),
        .operand_i  (op_q),
        .mode_div_i (is_div),
        .acc_o      (step_acc),
        .q_bit_o    (step_q_bit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        con_d     = con_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div0_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // kill in the same cycle suppresses the start.
                if (start && !kill && is_muldiv(con)) begin
                    a_d     = a;
                    b_d     = b;
                    con_d   = con[1:0];
                    state_d = StPrep;
                end
            end
            StPrep: begin
                neg_quo_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = is_signed & a_q[WIDTH-1];
                // Upper half cleared; lower half holds the value consumed
                // bit by bit (multiplier, or dividend).
                if (is_div) begin
                    acc_d = {{WIDTH{1'b0}}, mag_a};
                    op_d  = mag_b;
                end else begin
                    acc_d = {{WIDTH{1'b0}}, mag_b};
                    op_d  = mag_a;
                end
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_div && (b_q == '0)) begin
                    lo_d   = '1;
                    hi_d   = a_q;
                    div0_d = 1'b1;
                end else if (is_div) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (kill && (state_q != StIdle)) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            div0_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            con_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            con_q     <= con_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign stall    = busy & (start | hilo_rd);
    assign done     = done_q;
    assign div0     = div0_q;
    assign hilo_out = hilo_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  con = 4'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        kill = 1'b0;
    logic        hilo_rd = 1'b0;
    logic        hilo_sel = 1'b0;
    logic [31:0] hilo_out;
    logic        busy, stall, done, div0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .con      (con),
        .a        (a),
        .b        (b),
        .kill     (kill),
        .hilo_rd  (hilo_rd),
        .hilo_sel (hilo_sel),
        .hilo_out (hilo_out),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .div0     (div0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural values.
    task automatic model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] p;
        longint      sx, sy, q, r;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        if (c == CON_MULTU) begin
            p  = {32'b0, x} * {32'b0, y};
            hi = p[63:32];
            lo = p[31:0];
        end else if (c == CON_MULT) begin
            p  = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            hi = p[63:32];
            lo = p[31:0];
        end else if (y == 32'd0) begin
            dz = 1'b1;
            lo = 32'hFFFF_FFFF;
            hi = x;
        end else if (c == CON_DIVU) begin
            lo = x / y;
            hi = x % y;
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = sx / sy;
            r  = sx % sy;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        hilo_sel = 1'b0;
        #1;
        chk({tag, " HI"}, hilo_out, ehi);
        hilo_sel = 1'b1;
        #1;
        chk({tag, " LO"}, hilo_out, elo);
    endtask

    // Issue one op, count busy cycles, check pulses and the committed result.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] y);
        logic [31:0] ehi, elo;
        logic        edz;
        int          n, early;
        model(c, x, y, ehi, elo, edz);
        start = 1'b1;
        con   = c;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        early = 0;
        while (busy && n < 100) begin
            if (done) early++;
            n++;
            @(posedge clk);
            #1;
        end
        chk({tag, " busy_len"}, n, 34);
        chk({tag, " early_done"}, early, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " div0"}, div0, edz);
        read_hilo(tag, ehi, elo);
        @(posedge clk);
        #1;
        chk({tag, " done_drop"}, done, 0);
        chk({tag, " div0_drop"}, div0, 0);
    endtask

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra, rb;
        int          n;

        // Reset
        rst_n   = 1'b0;
        start   = 1'b1;
        con     = CON_MULTU;
        kill    = 1'b1;
        hilo_rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst stall", stall, 0);
        chk("rst done", done, 0);
        chk("rst div0", div0, 0);
        read_hilo("rst", 32'h0, 32'h0);
        start   = 1'b0;
        kill    = 1'b0;
        hilo_rd = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_op("multu_max", CON_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg", CON_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op("div_neg", CON_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_big", CON_DIVU, 32'h8000_0000, 32'd3);
        run_op("div_ovf", CON_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero", CON_DIV, 32'h0000_1234, 32'd0);
        run_op("divu_zero", CON_DIVU, 32'h8765_4321, 32'd0);

        // Non-HI/LO control code is ignored
        start = 1'b1;
        con   = 4'b1000;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("bad_con busy", busy, 0);

        // kill with start in IDLE: start ignored
        start = 1'b1;
        kill  = 1'b1;
        con   = CON_MULTU;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        chk("idle_kill busy", busy, 0);

        // Stall on reads and on a second start while busy
        start = 1'b1;
        con   = CON_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start    = 1'b0;
        hilo_rd  = 1'b1;
        hilo_sel = 1'b1;
        n        = 0;
        while (busy && n < 100) begin
            #1;
            chk("stall_rd", stall, 1);
            n++;
            if (n == 5) begin
                start = 1'b1;
                a     = 32'd4;
                b     = 32'd5;
            end
            @(posedge clk);
            #1;
        end
        chk("stall busy_len", n, 34);
        chk("stall released", stall, 0);
        chk("stall first_read", hilo_out, 32'd6);
        @(posedge clk);
        #1;
        chk("held start accepted", busy, 1);
        start   = 1'b0;
        hilo_rd = 1'b0;
        n       = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("held busy_len", n, 34);
        read_hilo("held", 32'd0, 32'd20);

        // kill mid-RUN keeps the preloaded HI/LO
        run_op("preload", CON_DIVU, 32'd47, 32'd7);
        start = 1'b1;
        con   = CON_DIVU;
        a     = 32'd100;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill busy", busy, 0);
        n = 0;
        repeat (4) begin
            if (done) n++;
            @(posedge clk);
            #1;
        end
        chk("kill no_done", n, 0);
        read_hilo("kill", 32'd5, 32'd6);

        // Reset mid-RUN
        start = 1'b1;
        con   = CON_DIVU;
        a     = 32'd100;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        hilo_rd = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst stall", stall, 0);
        chk("midrst done", done, 0);
        chk("midrst div0", div0, 0);
        read_hilo("midrst", 32'd0, 32'd0);
        rst_n   = 1'b1;
        hilo_rd = 1'b0;
        @(posedge clk);
        #1;

        // Randomized ops
        for (int i = 0; i < 24; i++) begin
            rc = {2'b11, 2'($urandom_range(0, 3))};
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (i % 5 == 0) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d", i), rc, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
